// File: rtl/eb_skp_delete_ctrl.sv
// Write-side SKP ordered-set controller for the RX elastic buffer: 5-stage delay line with 4-symbol SKP deletion.
// Optional statistics counters (del_cnt/err_cnt) are built only when EB_SKP_STATS_EN is defined.
module eb_skp_delete_ctrl #(
    parameter int unsigned MIN_SKP    = 4,
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  LTSSM_rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_os_start,
    input  logic                  SKP_remv_rqst,
    output logic                  write_en,
    output logic [7:0]            wdata,
    output logic                  skp_del,
    output logic                  skp_err,
    output logic [STAT_WIDTH-1:0] del_cnt,
    output logic [STAT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SKP_RUN, SKP_TAIL} state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       is_skp;
    } stage_t;

    localparam logic [7:0]           SKP_SYM = 8'hAA;
    localparam logic [7:0]           SKP_END = 8'hE1;
    localparam logic [CNT_WIDTH-1:0] DEL_MIN = CNT_WIDTH'(MIN_SKP + 4);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           tail;
    stage_t               s0, s1, s2, s3;

    logic is_aa, is_end, run_byte, entry, skp_in, stages_skp, do_del, bad;

    always_comb begin
        is_aa      = (rx_data == SKP_SYM);
        is_end     = (rx_data == SKP_END);
        run_byte   = rx_valid && (state == SKP_RUN);
        entry      = rx_valid && (state == IDLE) && rx_os_start && is_aa;
        skp_in     = entry || (run_byte && is_aa);
        stages_skp = s0.valid && s0.is_skp && s1.valid && s1.is_skp &&
                     s2.valid && s2.is_skp && s3.valid && s3.is_skp;
        // The four stages hold the last four SKP symbols when SKP_END is at the input.
        do_del     = run_byte && is_end && SKP_remv_rqst && (cnt >= DEL_MIN) && stages_skp;
        bad        = run_byte && !is_aa && !is_end;
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst || LTSSM_rst) begin
            s0       <= '0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            write_en <= 1'b0;
            wdata    <= '0;
            skp_del  <= 1'b0;
            skp_err  <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            tail     <= '0;
        end else begin
            write_en <= s3.valid && !do_del;
            wdata    <= s3.data;
            s3       <= s2;
            s2       <= s1;
            s1       <= s0;
            s0       <= {rx_valid, rx_data, skp_in};
            skp_del  <= do_del;
            skp_err  <= bad;
            if (do_del) begin
                s3.valid <= 1'b0;
                s2.valid <= 1'b0;
                s1.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (entry) begin
                        state <= SKP_RUN;
                        cnt   <= CNT_WIDTH'(1);
                    end
                end
                SKP_RUN: begin
                    if (rx_valid) begin
                        if (is_aa) begin
                            if (cnt != '1)
                                cnt <= cnt + 1'b1;
                        end else if (is_end) begin
                            state <= SKP_TAIL;
                            tail  <= 2'd3;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SKP_TAIL: begin
                    if (rx_valid) begin
                        tail <= tail - 1'b1;
                        if (tail == 2'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EB_SKP_STATS_EN
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            del_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (skp_del && (del_cnt != '1))
                del_cnt <= del_cnt + 1'b1;
            if (skp_err && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign del_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule
